// File: rtl/umult_issue_q.sv
`default_nettype none
// ============================================================================
//  Module   : umult_issue_q
//  Brief    : Operand FIFO plus issue controller for umultiplier. Buffers up
//             to DEPTH unsigned operand pairs and issues them one at a time.
//             Each issue is a one-cycle start pulse with stable operands. The
//             next issue waits until the multiplier reports completion.
//  Options  : UMULT_ISSUE_TIMEOUT_EN - adds a WAIT-state watchdog (TIMEOUT
//             cycles) and the timeout_err output port.
//  Revision : 1.0 - initial release
// ============================================================================
module umult_issue_q #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4
`ifdef UMULT_ISSUE_TIMEOUT_EN
   ,parameter int TIMEOUT = 32
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    // producer side
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    // multiplier side
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    output logic                     mult_start,
    input  logic                     mult_busy,
    input  logic                     mult_valid,
    // status
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     inflight
`ifdef UMULT_ISSUE_TIMEOUT_EN
   ,output logic                     timeout_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] C_PTR_ONE = 1;
    localparam logic [CW-1:0] C_CNT_ONE = 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_mem_a [DEPTH];
    logic [WIDTH-1:0]  r_mem_b [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [WIDTH-1:0]  r_mult_a;
    logic [WIDTH-1:0]  r_mult_b;
    logic              r_mult_start;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_timeout;

    // Flags come from the registered count only, so in_ready has no
    // combinational dependence on in_valid.
    assign w_full   = (r_count == C_CNT_MAX);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;

    assign in_ready   = !w_full;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign mult_start = r_mult_start;
    assign inflight   = (r_state != S_IDLE);

`ifdef UMULT_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] C_TO_ONE  = 1;

    logic [TW-1:0]     r_wait_cnt;
    logic              r_timeout_err;

    assign timeout_err = r_timeout_err;

    // WAIT-cycle counter: zero outside WAIT, so it reads n-1 in the n-th WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + C_TO_ONE;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and pop decode; a pop only ever happens on IDLE->ISSUE.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
`ifdef UMULT_ISSUE_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !mult_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final allowed cycle beats the watchdog.
                if (mult_valid) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef UMULT_ISSUE_TIMEOUT_EN
                else if (r_wait_cnt == C_TO_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array; entries are only meaningful between pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // Pointers and occupancy; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Operand and start registers; operands change only when an entry is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_mult_start <= 1'b0;
        end else begin
            r_mult_start <= w_pop;
            if (w_pop) begin
                r_mult_a <= r_mem_a[r_rd_ptr];
                r_mult_b <= r_mem_b[r_rd_ptr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_umult_issue_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_umult_issue_q
//  Brief    : Directed self-checking bench for umult_issue_q, with a small
//             fixed-latency multiplier stub and a start-pulse monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_umult_issue_q;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_ready;
    logic [3:0] mult_a;
    logic [3:0] mult_b;
    logic       mult_start;
    logic       mult_busy;
    logic       mult_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       inflight;
`ifdef UMULT_ISSUE_TIMEOUT_EN
    logic       timeout_err;
`endif

    int checks   = 0;
    int failures = 0;

    // multiplier stub (stub_en) or manual busy/valid control
    logic       stub_en   = 1'b0;
    logic       man_busy  = 1'b0;
    logic       man_valid = 1'b0;
    logic       stub_busy = 1'b0;
    logic       stub_valid = 1'b0;
    int         stub_cnt  = 0;
    logic [7:0] stub_z    = '0;
    logic [7:0] z_log [64];
    int         z_n       = 0;

    assign mult_busy  = stub_en ? stub_busy  : man_busy;
    assign mult_valid = stub_en ? stub_valid : man_valid;

    umult_issue_q #(.WIDTH(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_start (mult_start),
        .mult_busy  (mult_busy),
        .mult_valid (mult_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .inflight   (inflight)
`ifdef UMULT_ISSUE_TIMEOUT_EN
       ,.timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Fixed-latency multiplier stub: busy for LAT cycles, then one valid pulse.
    always @(posedge clk) begin
        if (rst) begin
            stub_busy  <= 1'b0;
            stub_valid <= 1'b0;
            stub_cnt   <= 0;
        end else begin
            stub_valid <= 1'b0;
            if (stub_busy) begin
                if (stub_cnt == 0) begin
                    stub_busy  <= 1'b0;
                    stub_valid <= 1'b1;
                    if (z_n < 64) z_log[z_n] <= stub_z;
                    z_n <= z_n + 1;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end else if (stub_en && mult_start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= LAT - 1;
                stub_z    <= {4'b0, mult_a} * {4'b0, mult_b};
            end
        end
    end

    // Start-pulse monitor: records operands and how many completions preceded it.
    logic [3:0] mon_a [64];
    logic [3:0] mon_b [64];
    int         mon_zn [64];
    int         mon_n = 0;

    always @(negedge clk) begin
        if (!rst && mult_start) begin
            if (mon_n < 64) begin
                mon_a[mon_n]  = mult_a;
                mon_b[mon_n]  = mult_b;
                mon_zn[mon_n] = z_n;
            end
            mon_n = mon_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        man_busy  = 1'b0;
        man_valid = 1'b0;
        stub_en   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (count !== 3'd0)      begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end checks++;
        if (empty !== 1'b1)      begin failures++; $display("FAIL reset_empty: got %0b expected 1", empty); end checks++;
        if (full !== 1'b0)       begin failures++; $display("FAIL reset_full: got %0b expected 0", full); end checks++;
        if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end checks++;
        if (mult_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %0b expected 0", mult_start); end checks++;
        if (mult_a !== 4'd0)     begin failures++; $display("FAIL reset_mult_a: got %0d expected 0", mult_a); end checks++;
        if (mult_b !== 4'd0)     begin failures++; $display("FAIL reset_mult_b: got %0d expected 0", mult_b); end checks++;
        if (inflight !== 1'b0)   begin failures++; $display("FAIL reset_inflight: got %0b expected 0", inflight); end checks++;
`ifdef UMULT_ISSUE_TIMEOUT_EN
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %0b expected 0", timeout_err); end checks++;
`endif
    endtask

    task automatic test_single();
        logic [7:0] prod;
        do_reset();
        in_a = 4'd4; in_b = 4'd2; in_valid = 1'b1;
        tick();                          // edge k: accepted
        in_valid = 1'b0;
        if (mult_start !== 1'b0) begin failures++; $display("FAIL single_no_early_start: got %0b expected 0", mult_start); end checks++;
        if (count !== 3'd1)      begin failures++; $display("FAIL single_count1: got %0d expected 1", count); end checks++;
        tick();                          // edge k+1: issued
        if (mult_start !== 1'b1) begin failures++; $display("FAIL single_start: got %0b expected 1", mult_start); end checks++;
        if (mult_a !== 4'd4)     begin failures++; $display("FAIL single_a: got %0d expected 4", mult_a); end checks++;
        if (mult_b !== 4'd2)     begin failures++; $display("FAIL single_b: got %0d expected 2", mult_b); end checks++;
        if (inflight !== 1'b1)   begin failures++; $display("FAIL single_inflight: got %0b expected 1", inflight); end checks++;
        if (count !== 3'd0)      begin failures++; $display("FAIL single_count0: got %0d expected 0", count); end checks++;
        prod = {4'b0, mult_a} * {4'b0, mult_b};
        if (prod !== 8'd8)       begin failures++; $display("FAIL single_product: got %0d expected 8", prod); end checks++;
        tick();                          // WAIT
        if (mult_start !== 1'b0) begin failures++; $display("FAIL single_start_pulse: got %0b expected 0", mult_start); end checks++;
        tick(); tick(); tick();
        if (mult_a !== 4'd4)     begin failures++; $display("FAIL single_a_hold: got %0d expected 4", mult_a); end checks++;
        if (inflight !== 1'b1)   begin failures++; $display("FAIL single_inflight_wait: got %0b expected 1", inflight); end checks++;
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        if (inflight !== 1'b0)   begin failures++; $display("FAIL single_inflight_drop: got %0b expected 0", inflight); end checks++;
    endtask

    task automatic test_burst();
        logic [3:0] ea [4] = '{4'd4, 4'd6, 4'd15, 4'd0};
        logic [3:0] eb [4] = '{4'd2, 4'd4, 4'd15, 4'd9};
        logic [7:0] ez [4] = '{8'd8, 8'd24, 8'd225, 8'd0};
        int base;
        int zb;
        int t;
        do_reset();
        stub_en = 1'b1;
        base = mon_n;
        zb   = z_n;
        for (int i = 0; i < 4; i++) begin
            in_a = ea[i]; in_b = eb[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        t = 0;
        while (z_n < zb + 4 && t < 300) begin
            tick();
            t++;
        end
        if (z_n < zb + 4) begin failures++; $display("FAIL burst_timeout: got %0d completions expected 4", z_n - zb); end checks++;
        tick(); tick(); tick();
        if (mon_n - base !== 4) begin failures++; $display("FAIL burst_starts: got %0d expected 4", mon_n - base); end checks++;
        for (int i = 0; i < 4; i++) begin
            if (mon_a[base+i] !== ea[i])    begin failures++; $display("FAIL burst_a%0d: got %0d expected %0d", i, mon_a[base+i], ea[i]); end checks++;
            if (mon_b[base+i] !== eb[i])    begin failures++; $display("FAIL burst_b%0d: got %0d expected %0d", i, mon_b[base+i], eb[i]); end checks++;
            if (z_log[zb+i] !== ez[i])      begin failures++; $display("FAIL burst_z%0d: got %0d expected %0d", i, z_log[zb+i], ez[i]); end checks++;
            if (mon_zn[base+i] !== zb + i)  begin failures++; $display("FAIL burst_order%0d: got %0d prior completions expected %0d", i, mon_zn[base+i] - zb, i); end checks++;
        end
        if (inflight !== 1'b0) begin failures++; $display("FAIL burst_idle: got %0b expected 0", inflight); end checks++;
        stub_en = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        man_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = 4'(i + 1); in_b = 4'(i + 8); in_valid = 1'b1;
            tick();
            if (i == 3) begin
                if (count !== 3'd4)    begin failures++; $display("FAIL full_count4: got %0d expected 4", count); end checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end checks++;
                if (full !== 1'b1)     begin failures++; $display("FAIL full_flag: got %0b expected 1", full); end checks++;
            end
        end
        in_valid = 1'b0;
        if (count !== 3'd4)      begin failures++; $display("FAIL full_fifth_dropped: got %0d expected 4", count); end checks++;
        if (mult_start !== 1'b0) begin failures++; $display("FAIL full_busy_hold: got %0b expected 0", mult_start); end checks++;
        man_busy = 1'b0;
        tick();
        if (count !== 3'd3)      begin failures++; $display("FAIL full_count3: got %0d expected 3", count); end checks++;
        if (in_ready !== 1'b1)   begin failures++; $display("FAIL full_in_ready_back: got %0b expected 1", in_ready); end checks++;
        if (mult_start !== 1'b1) begin failures++; $display("FAIL full_start: got %0b expected 1", mult_start); end checks++;
        if (mult_a !== 4'd1)     begin failures++; $display("FAIL full_head_a: got %0d expected 1", mult_a); end checks++;
        if (mult_b !== 4'd8)     begin failures++; $display("FAIL full_head_b: got %0d expected 8", mult_b); end checks++;
    endtask

    task automatic test_push_pop();
        logic [3:0] qa [$];
        logic [3:0] qb [$];
        logic [3:0] xa;
        logic [3:0] xb;
        logic [3:0] na;
        logic [3:0] nb;
        do_reset();
        man_busy = 1'b1;
        in_a = 4'd10; in_b = 4'd1; in_valid = 1'b1; tick();
        in_a = 4'd11; in_b = 4'd2; tick();
        in_valid = 1'b0;
        qa.push_back(4'd10); qb.push_back(4'd1);
        qa.push_back(4'd11); qb.push_back(4'd2);
        if (count !== 3'd2) begin failures++; $display("FAIL pp_preload: got %0d expected 2", count); end checks++;
        for (int i = 0; i < 12; i++) begin
            na = 4'(i * 3 + 1);
            nb = 4'(15 - i);
            in_a = na; in_b = nb; in_valid = 1'b1; man_busy = 1'b0;
            xa = qa.pop_front();
            xb = qb.pop_front();
            qa.push_back(na);
            qb.push_back(nb);
            tick();
            in_valid = 1'b0; man_busy = 1'b1;
            if (count !== 3'd2)      begin failures++; $display("FAIL pp_count%0d: got %0d expected 2", i, count); end checks++;
            if (mult_start !== 1'b1) begin failures++; $display("FAIL pp_start%0d: got %0b expected 1", i, mult_start); end checks++;
            if (mult_a !== xa)       begin failures++; $display("FAIL pp_a%0d: got %0d expected %0d", i, mult_a, xa); end checks++;
            if (mult_b !== xb)       begin failures++; $display("FAIL pp_b%0d: got %0d expected %0d", i, mult_b, xb); end checks++;
            tick();
            man_valid = 1'b1;
            tick();
            man_valid = 1'b0;
        end
    endtask

    task automatic test_reset_wait();
        int base;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_a = 4'(i + 1); in_b = 4'(i + 1); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (count !== 3'd3)    begin failures++; $display("FAIL rw_queued: got %0d expected 3", count); end checks++;
        if (inflight !== 1'b1) begin failures++; $display("FAIL rw_in_wait: got %0b expected 1", inflight); end checks++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (count !== 3'd0)      begin failures++; $display("FAIL rw_count: got %0d expected 0", count); end checks++;
        if (empty !== 1'b1)      begin failures++; $display("FAIL rw_empty: got %0b expected 1", empty); end checks++;
        if (inflight !== 1'b0)   begin failures++; $display("FAIL rw_inflight: got %0b expected 0", inflight); end checks++;
        if (mult_a !== 4'd0)     begin failures++; $display("FAIL rw_mult_a: got %0d expected 0", mult_a); end checks++;
        base = mon_n;
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        repeat (10) tick();
        if (mon_n !== base)    begin failures++; $display("FAIL rw_no_start: got %0d starts expected 0", mon_n - base); end checks++;
        if (inflight !== 1'b0) begin failures++; $display("FAIL rw_stale_valid: got %0b expected 0", inflight); end checks++;
    endtask

`ifdef UMULT_ISSUE_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        do_reset();
        in_a = 4'd5; in_b = 4'd3; in_valid = 1'b1; tick();
        in_a = 4'd7; in_b = 4'd2; tick();
        in_valid = 1'b0;
        if (mult_start !== 1'b1) begin failures++; $display("FAIL to_first_start: got %0b expected 1", mult_start); end checks++;
        bad = 0;
        for (int n = 0; n < 32; n++) begin
            tick();
            if (timeout_err !== 1'b0 || inflight !== 1'b1) bad++;
        end
        if (bad != 0) begin failures++; $display("FAIL to_early: got %0d bad WAIT cycles expected 0", bad); end checks++;
        tick();
        if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_pulse: got %0b expected 1", timeout_err); end checks++;
        if (inflight !== 1'b0)    begin failures++; $display("FAIL to_idle: got %0b expected 0", inflight); end checks++;
        tick();
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_len: got %0b expected 0", timeout_err); end checks++;
        if (mult_start !== 1'b1)  begin failures++; $display("FAIL to_next_start: got %0b expected 1", mult_start); end checks++;
        if (mult_a !== 4'd7)      begin failures++; $display("FAIL to_next_a: got %0d expected 7", mult_a); end checks++;
        repeat (32) tick();
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_valid_wins: got %0b expected 0", timeout_err); end checks++;
        if (inflight !== 1'b0)    begin failures++; $display("FAIL to_valid_idle: got %0b expected 0", inflight); end checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_push_pop();
        test_reset_wait();
`ifdef UMULT_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/umult_issue_q.md
# umult_issue_q

Operand queue and issue controller sitting directly upstream of `umultiplier`. Buffers up to DEPTH unsigned operand pairs from a valid/ready producer and issues them one at a time to the multiplier. Each issue is a single-cycle start pulse with stable operands, and the next pair is not issued until the multiplier reports completion. This decouples bursty operand sources from the multi-cycle multiplier.

## Interface
- `WIDTH`, 4, operand width; must match the multiplier's `WIDTH`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TIMEOUT`, 32, max WAIT cycles before abort; present only with `UMULT_ISSUE_TIMEOUT_EN`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a pair on `in_a`/`in_b`.
- `in_ready`  out  1  `!full`; a pair is accepted on an edge where `in_valid && in_ready`.
- `in_a`, `in_b`  in  WIDTH  operands.
- `mult_a`, `mult_b`  out  WIDTH  registered operands to the multiplier `A`/`B`.
- `mult_start`  out  1  one-cycle start pulse to the multiplier `start`.
- `mult_busy`  in  1  multiplier `busy_out`.
- `mult_valid`  in  1  multiplier `valid_out`; marks completion.
- `count`  out  $clog2(DEPTH)+1  queued entries.
- `full`, `empty`  out  1  `count==DEPTH`, `count==0`.
- `inflight`  out  1  high while in ISSUE or WAIT.
- `timeout_err`  out  1  one-cycle abort pulse; port exists only with the macro.

## Operation
- FIFO: circular buffer with wrapping read/write pointers and an explicit `count`.
  - Push when `in_valid && !full`. `in_valid` while full is ignored and does not stall state.
  - Pop occurs only on the IDLE→ISSUE transition.
  - Simultaneous push and pop: `count` unchanged; both pointers advance.
- States:
  - IDLE: if `!empty && !mult_busy`, pop head into `mult_a`/`mult_b`, assert `mult_start`, go to ISSUE. Otherwise stay.
  - ISSUE: exactly one cycle; `mult_start` deasserts; go to WAIT.
  - WAIT: if `mult_valid` is high, go to IDLE. Otherwise stay.
- `mult_valid` seen in IDLE or ISSUE is ignored.
- `mult_a`/`mult_b` hold their value from issue until the next issue; they never change in ISSUE or WAIT.
- `inflight` = state ≠ IDLE.
- No arithmetic on data; operands pass through bit-exact and zero operands are legal.

## Timing
- Reset values, applied on the first edge with `rst=1`:
  - pointers, `count` = 0; `empty` = 1; `full` = 0; `in_ready` = 1.
  - state IDLE; `mult_start` = 0; `mult_a` = `mult_b` = 0; `inflight` = 0; `timeout_err` = 0.
- Reset mid-operation discards all queued entries and abandons any in-flight multiply. A later `mult_valid` from that multiply is ignored in IDLE.
- Issue latency:
  - A pair accepted at edge k into an empty queue with the multiplier idle: `mult_start` is high in the cycle after edge k+1.
  - The new entry is not poppable on its own accepting edge.
- Throughput: one issue per (multiplier latency + 2) cycles. The earliest next `mult_start` is on the edge after the edge that samples `mult_valid`.
- `in_ready` depends only on registered `count`; there is no combinational path from `in_valid`.

## Configuration
- `UMULT_ISSUE_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - After TIMEOUT WAIT cycles without `mult_valid`, pulse `timeout_err` for one cycle and return to IDLE; the entry is dropped.
  - A `mult_valid` arriving on the TIMEOUT-th cycle wins, and no error is raised.
- Undefined: no counter, no `timeout_err` port, and WAIT lasts indefinitely.

## Test plan
- Single op: after reset, push (4,2) → `mult_start` pulses once with `mult_a`=4, `mult_b`=2; with `umultiplier` attached, Z=8. `inflight` drops the edge after `valid_out`.
- Burst: push (4,2),(6,4),(15,15),(0,9) back-to-back → four start pulses in order. Z = 8, 24, 225, 0; each start occurs only after the previous `valid_out`.
- Full: push 5 pairs with the multiplier held busy → `in_ready`=0 after the 4th; the 5th is not accepted; `count`=4. Releasing busy → `count` 3 and `in_ready`=1.
- Simultaneous push/pop at `count`=2: `count` stays 2 and pointers wrap correctly over 3 passes of DEPTH.
- Reset in WAIT: `rst` pulse with 3 queued → `count`=0, IDLE, no further starts. A stale `mult_valid` is ignored.
- Timeout (macro on, TIMEOUT=32): stub never returns valid → `timeout_err` pulses 32 WAIT cycles after ISSUE, and the next entry is issued.
